logic_unit_serial: RTL



---
 rtl/logic_unit_serial.sv | 138 +++++++++++++
 1 files changed

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per cycle.
// Optional registered parity output enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int unsigned N    = WIDTH / SLICE;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("logic_unit_serial: WIDTH must be an integer multiple of SLICE");
    end

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [1:0]       op_q,     op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity_q, parity_d;
`endif

    function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       o,
                                                  input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y);
        logic [SLICE-1:0] r;
        case (o)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x | y);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        result_d[i*SLICE +: SLICE] =
                            slice_op(op_q, a_q[i*SLICE +: SLICE], b_q[i*SLICE +: SLICE]);
                    end
                end
                // Flags are taken from the fully written result so they line up with done.
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    zero_d   = ~|result_d;
`ifdef LOGIC_UNIT_PARITY_EN
                    parity_d = ^result_d;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign zero   = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
    assign parity = parity_q;
`endif

endmodule
